bus_exchange_reg: RTL and testbench
===================================

Name: bus_exchange_reg

Overview:
- Parametrised, registered successor to the 32-bit A/B, C/D bidirectional data exchanger.
- Supports CHANNELS independent A<->B channels, each WIDTH bits wide.
- Each channel has its own direction control and a programmable dead-time (turnaround) in which neither side drives. This prevents bus contention when the direction changes.
- Tri-state pads live at the top level. This block exposes split in/out/oe per side and sits directly behind the pad ring.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 2, number of independent exchange channels (CHANNELS >= 1).
- TURN_CYCLES, 2, dead cycles with both oe low on every direction change or enable (TURN_CYCLES >= 1).

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- chan_en  in  CHANNELS  per-channel enable. 0 forces the channel to idle (nobody drives).
- dir_req  in  CHANNELS  per-channel requested direction. 0 = A->B, 1 = B->A.
- a_in  in  CHANNELS*WIDTH  pad input, A side; channel c occupies bits [c*WIDTH +: WIDTH].
- a_out  out  CHANNELS*WIDTH  pad output data, A side.
- a_oe  out  CHANNELS  A-side output enable, one per channel.
- b_in  in  CHANNELS*WIDTH  pad input, B side.
- b_out  out  CHANNELS*WIDTH  pad output data, B side.
- b_oe  out  CHANNELS  B-side output enable, one per channel.
- dir_ack  out  CHANNELS  direction currently being driven; valid only while active is 1.
- active  out  CHANNELS  1 = channel in DRIVE.
- busy  out  CHANNELS  1 = channel in TURN.

Behaviour:
- Reset (rst_n=0 at a clock edge), applied to every channel:
  - state=IDLE; a_oe=b_oe=0; a_out=b_out=0; dir_ack=0; active=0; busy=0; turn counter=0.
  - Reset overrides all other inputs in that cycle.
  - Reset in the middle of TURN or DRIVE drops both oe on the next edge. No partial turnaround is kept.
- Data path:
  - Every cycle, b_out <= a_in and a_out <= b_in, independent of state.
  - Latency from input to the opposite output is 1 cycle.
  - Data is valid on the first DRIVE cycle because capture never stops.
- Per-channel FSM. States are IDLE, TURN and DRIVE; all outputs are registered.
  - IDLE:
    - chan_en=1 -> TURN; counter loaded with TURN_CYCLES-1.
  - TURN:
    - a_oe=b_oe=0, busy=1.
    - chan_en=0 -> IDLE.
    - Counter decrements each cycle.
    - At counter==0 -> DRIVE; cur_dir <= dir_req sampled on that same edge, so a dir_req change during TURN is honoured.
  - DRIVE:
    - active=1, dir_ack=cur_dir.
    - b_oe = ~cur_dir; a_oe = cur_dir.
    - chan_en=0 -> IDLE.
    - Else dir_req != cur_dir -> TURN, counter reloaded.
    - Else stay in DRIVE.
- Timing:
  - oe falls on the edge that leaves DRIVE. The first edge with the new oe set is exactly TURN_CYCLES cycles after oe fell.
  - a_oe and b_oe are never both 1. This holds in every cycle, including during reset.
  - TURN is entered only from IDLE or DRIVE.
- Simultaneous events:
  - chan_en=0 has priority over a direction change.
  - A dir_req glitch shorter than one cycle in DRIVE is not filtered; a full turnaround occurs.
- Channels are fully independent. There is no shared state between channels.
- Counter width is $clog2(TURN_CYCLES+1). There is no wrap-around; the counter is reloaded on entry to TURN.

Decomposition:
- Shared package bus_exch_pkg holds:
  - the state encoding (IDLE=2'd0, TURN=2'd1, DRIVE=2'd2);
  - the direction constants DIR_AB=1'b0 and DIR_BA=1'b1.
- One sub-module, bus_exch_chan: one channel's FSM, turnaround counter, and WIDTH-bit data registers.
- The top generates CHANNELS instances and slices the flat buses.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with chan_en=all 1 and a_in=all 1s -> all oe=0, all outputs 0, active=busy=0. On release, busy=1 on the next edge.
- Enable A->B on ch0 (TURN_CYCLES=2, dir_req=0, chan_en=1 at cycle 0) -> busy at cycles 1-2; b_oe=1 and active=1 at cycle 3. Drive a_in=32'hDEADBEEF at cycle 5 -> b_out=32'hDEADBEEF at cycle 6.
- Direction flip: ch0 in DRIVE A->B, set dir_req=1 at cycle N -> b_oe=0 at N+1, both oe 0 for 2 cycles, a_oe=1 at N+3, dir_ack=1. Checker asserts a_oe&b_oe==0 every cycle.
- Request reversal during TURN: flip dir_req 0->1, then back to 0 one cycle later -> channel re-enters DRIVE with dir_ack=0 and b_oe=1 after exactly 2 dead cycles.
- Disable priority: in DRIVE, change dir_req and deassert chan_en on the same edge -> IDLE next cycle, busy=0, both oe 0.
- Channel independence: with CHANNELS=4, flip ch2 repeatedly -> ch0/1/3 oe and data outputs show no disturbance. Also rerun with TURN_CYCLES=1 and WIDTH=8: dead time is 1 cycle.

Source files
------------

// File: rtl/bus_exch_pkg.sv
// Shared encodings for the bus exchange block: per-channel FSM states and
// direction constants.
package bus_exch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } chanState_t;

  localparam logic DIR_AB = 1'b0;
  localparam logic DIR_BA = 1'b1;

endpackage

// File: rtl/bus_exch_chan.sv
// One exchange channel: free-running cross-capture data registers plus an
// IDLE/TURN/DRIVE controller that inserts dead cycles on every turnaround.
module bus_exch_chan
  import bus_exch_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chanEn,
  input  logic             dirReq,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH-1:0] aOut,
  output logic [WIDTH-1:0] bOut,
  output logic             aOe,
  output logic             bOe,
  output logic             dirAck,
  output logic             active,
  output logic             busy,
  output chanState_t       stateDbg
);

  localparam int CNT_W = $clog2(TURN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYCLES - 1);

  chanState_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             curDir, curDirNext;
  logic             aOeNext, bOeNext, dirAckNext, activeNext, busyNext;

  // State, counter, registered outputs and data path. Data capture never
  // stops so the first DRIVE cycle already carries valid data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      curDir <= DIR_AB;
      aOe    <= 1'b0;
      bOe    <= 1'b0;
      dirAck <= 1'b0;
      active <= 1'b0;
      busy   <= 1'b0;
      aOut   <= '0;
      bOut   <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      curDir <= curDirNext;
      aOe    <= aOeNext;
      bOe    <= bOeNext;
      dirAck <= dirAckNext;
      active <= activeNext;
      busy   <= busyNext;
      aOut   <= bIn;
      bOut   <= aIn;
    end
  end

  // Disable wins over a direction change; direction is latched only when
  // the turnaround completes, so late requests during TURN are honoured.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    curDirNext = curDir;
    case (state)
      IDLE: begin
        if (chanEn) begin
          stateNext = TURN;
          cntNext   = CNT_LOAD;
        end
      end
      TURN: begin
        if (!chanEn) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext  = DRIVE;
          curDirNext = dirReq;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!chanEn) begin
          stateNext = IDLE;
        end else if (dirReq != curDir) begin
          stateNext = TURN;
          cntNext   = CNT_LOAD;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // dir_ack is meaningful only while active; it is held at DIR_AB otherwise.
  always_comb begin
    activeNext = (stateNext == DRIVE);
    busyNext   = (stateNext == TURN);
    aOeNext    = activeNext && (curDirNext == DIR_BA);
    bOeNext    = activeNext && (curDirNext == DIR_AB);
    dirAckNext = activeNext ? curDirNext : DIR_AB;
  end

  assign stateDbg = state;

endmodule

// File: rtl/bus_exchange_reg.sv
// Registered multi-channel A<->B exchanger sitting behind the pad ring;
// exposes split in/out/oe per side and one independent channel per slice.
module bus_exchange_reg
  import bus_exch_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic [CHANNELS-1:0]       dir_req,
  input  logic [CHANNELS*WIDTH-1:0] a_in,
  output logic [CHANNELS*WIDTH-1:0] a_out,
  output logic [CHANNELS-1:0]       a_oe,
  input  logic [CHANNELS*WIDTH-1:0] b_in,
  output logic [CHANNELS*WIDTH-1:0] b_out,
  output logic [CHANNELS-1:0]       b_oe,
  output logic [CHANNELS-1:0]       dir_ack,
  output logic [CHANNELS-1:0]       active,
  output logic [CHANNELS-1:0]       busy,
  output logic [2*CHANNELS-1:0]     dbgState
);

  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    chanState_t chanState;

    bus_exch_chan #(
      .WIDTH      (WIDTH),
      .TURN_CYCLES(TURN_CYCLES)
    ) uChan (
      .clk     (clk),
      .rst_n   (rst_n),
      .chanEn  (chan_en[c]),
      .dirReq  (dir_req[c]),
      .aIn     (a_in[c*WIDTH +: WIDTH]),
      .bIn     (b_in[c*WIDTH +: WIDTH]),
      .aOut    (a_out[c*WIDTH +: WIDTH]),
      .bOut    (b_out[c*WIDTH +: WIDTH]),
      .aOe     (a_oe[c]),
      .bOe     (b_oe[c]),
      .dirAck  (dir_ack[c]),
      .active  (active[c]),
      .busy    (busy[c]),
      .stateDbg(chanState)
    );

    assign dbgState[2*c +: 2] = chanState;
  end

endmodule

// File: tb/tb_bus_exchange_reg.sv
// Bench for bus_exchange_reg: a 4-channel/32-bit/2-dead-cycle instance and a
// 2-channel/8-bit/1-dead-cycle instance checked against a behavioural model.
module tb_bus_exchange_reg;

  localparam int W0 = 32, C0 = 4, T0 = 2;
  localparam int W1 = 8,  C1 = 2, T1 = 1;

  typedef struct packed {
    logic [127:0] aOut;
    logic [127:0] bOut;
    logic [3:0]   aOe;
    logic [3:0]   bOe;
    logic [3:0]   dirAck;
    logic [3:0]   active;
    logic [3:0]   busy;
  } obs_t;

  typedef struct packed {
    obs_t i1;
    obs_t i0;
  } exp_t;

  // clock / reset
  logic clk;
  logic rstN;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0 signals
  logic [C0-1:0]    en0, dir0;
  logic [C0*W0-1:0] aIn0, bIn0, a_out0, b_out0;
  logic [C0-1:0]    a_oe0, b_oe0, dir_ack0, act0, busy0;
  logic [2*C0-1:0]  dbg0;

  // instance 1 signals
  logic [C1-1:0]    en1, dir1;
  logic [C1*W1-1:0] aIn1, bIn1, a_out1, b_out1;
  logic [C1-1:0]    a_oe1, b_oe1, dir_ack1, act1, busy1;
  logic [2*C1-1:0]  dbg1;

  bus_exchange_reg #(.WIDTH(W0), .CHANNELS(C0), .TURN_CYCLES(T0)) dut0 (
    .clk(clk), .rst_n(rstN), .chan_en(en0), .dir_req(dir0),
    .a_in(aIn0), .a_out(a_out0), .a_oe(a_oe0),
    .b_in(bIn0), .b_out(b_out0), .b_oe(b_oe0),
    .dir_ack(dir_ack0), .active(act0), .busy(busy0), .dbgState(dbg0)
  );

  bus_exchange_reg #(.WIDTH(W1), .CHANNELS(C1), .TURN_CYCLES(T1)) dut1 (
    .clk(clk), .rst_n(rstN), .chan_en(en1), .dir_req(dir1),
    .a_in(aIn1), .a_out(a_out1), .a_oe(a_oe1),
    .b_in(bIn1), .b_out(b_out1), .b_oe(b_oe1),
    .dir_ack(dir_ack1), .active(act1), .busy(busy1), .dbgState(dbg1)
  );

  // scoreboard
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: each channel is off, counting remaining dead cycles,
  // or driving in a direction.
  int deadLeft[2][4];
  bit drv[2][4];
  bit mDir[2][4];

  task automatic model_step(input int k, input bit rst, input logic [3:0] en,
                            input logic [3:0] dr, input logic [127:0] ai,
                            input logic [127:0] bi, input int tc, input int nch,
                            input int w, output obs_t o);
    logic [127:0] mask;
    o = '0;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        deadLeft[k][c] = 0;
        drv[k][c]      = 1'b0;
        mDir[k][c]     = 1'b0;
      end
    end else begin
      mask = (w * nch >= 128) ? '1 : ((128'(1) << (w * nch)) - 128'(1));
      for (int c = 0; c < nch; c++) begin
        if (!en[c]) begin
          drv[k][c]      = 1'b0;
          deadLeft[k][c] = 0;
        end else if (drv[k][c]) begin
          if (dr[c] != mDir[k][c]) begin
            drv[k][c]      = 1'b0;
            deadLeft[k][c] = tc;
          end
        end else if (deadLeft[k][c] > 0) begin
          deadLeft[k][c]--;
          if (deadLeft[k][c] == 0) begin
            drv[k][c]  = 1'b1;
            mDir[k][c] = dr[c];
          end
        end else begin
          deadLeft[k][c] = tc;
        end
        o.busy[c]   = deadLeft[k][c] > 0;
        o.active[c] = drv[k][c];
        o.dirAck[c] = drv[k][c] && mDir[k][c];
        o.aOe[c]    = drv[k][c] && mDir[k][c];
        o.bOe[c]    = drv[k][c] && !mDir[k][c];
      end
      o.bOut = ai & mask;
      o.aOut = bi & mask;
    end
  endtask

  // driver: inputs change only at the negedge; expectation for the next
  // posedge is pushed at the same time
  task automatic step();
    obs_t e0, e1;
    model_step(0, !rstN, en0, dir0, aIn0, bIn0, T0, C0, W0, e0);
    model_step(1, !rstN, 4'(en1), 4'(dir1), 128'(aIn1), 128'(bIn1), T1, C1, W1, e1);
    exp_q.push_back('{i1: e1, i0: e0});
    @(negedge clk);
  endtask

  task automatic cmp_obs(input string pfx, input obs_t a, input obs_t e);
    cmp({pfx, "_a_out"},   a.aOut,            e.aOut);
    cmp({pfx, "_b_out"},   a.bOut,            e.bOut);
    cmp({pfx, "_a_oe"},    128'(a.aOe),       128'(e.aOe));
    cmp({pfx, "_b_oe"},    128'(a.bOe),       128'(e.bOe));
    cmp({pfx, "_dir_ack"}, 128'(a.dirAck),    128'(e.dirAck));
    cmp({pfx, "_active"},  128'(a.active),    128'(e.active));
    cmp({pfx, "_busy"},    128'(a.busy),      128'(e.busy));
  endtask

  // monitor
  initial begin
    exp_t e;
    obs_t a0, a1;
    int   ill;
    forever begin
      @(posedge clk);
      #1;
      cmp("oe_exclusive", 128'({a_oe0 & b_oe0, a_oe1 & b_oe1}), 128'(0));
      ill = 0;
      for (int c = 0; c < C0; c++) if (dbg0[2*c +: 2] == 2'd3) ill++;
      for (int c = 0; c < C1; c++) if (dbg1[2*c +: 2] == 2'd3) ill++;
      cmp("state_legal", 128'(ill), 128'(0));
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        a0 = '{aOut: a_out0, bOut: b_out0, aOe: a_oe0, bOe: b_oe0,
               dirAck: dir_ack0, active: act0, busy: busy0};
        a1 = '{aOut: 128'(a_out1), bOut: 128'(b_out1), aOe: 4'(a_oe1), bOe: 4'(b_oe1),
               dirAck: 4'(dir_ack1), active: 4'(act1), busy: 4'(busy1)};
        cmp_obs("i0", a0, e.i0);
        cmp_obs("i1", a1, e.i1);
      end
    end
  end

  // stimulus
  initial begin
    rstN = 1'b0;
    en0  = '1; dir0 = '0; aIn0 = '1; bIn0 = '1;
    en1  = '1; dir1 = '0; aIn1 = '1; bIn1 = '1;
    @(negedge clk);

    // reset held with everything enabled and all-ones data
    repeat (3) step();
    cmp("rst_oe",     128'({a_oe0, b_oe0, a_oe1, b_oe1}), 128'(0));
    cmp("rst_data",   128'(b_out0), 128'(0));
    cmp("rst_status", 128'({act0, busy0, act1, busy1}), 128'(0));
    rstN = 1'b1;
    step();
    cmp("release_busy", 128'({busy0, busy1}), 128'(6'b111111));

    en0 = '0; en1 = '0; aIn0 = '0; bIn0 = '0;
    repeat (2) step();

    // enable A->B on ch0
    en0 = 4'b0001; dir0 = '0;
    step();
    cmp("en_busy1", 128'(busy0[0]), 128'(1));
    step();
    cmp("en_busy2", 128'({busy0[0], b_oe0[0]}), 128'(2'b10));
    step();
    cmp("en_drive", 128'({b_oe0[0], act0[0], a_oe0[0], busy0[0]}), 128'(4'b1100));
    aIn0[31:0] = 32'hDEADBEEF;
    step();
    cmp("data_ab", 128'(b_out0[31:0]), 128'(32'hDEADBEEF));

    // direction flip
    dir0[0] = 1'b1;
    step();
    cmp("flip_dead1", 128'({a_oe0[0], b_oe0[0]}), 128'(0));
    step();
    cmp("flip_dead2", 128'({a_oe0[0], b_oe0[0]}), 128'(0));
    step();
    cmp("flip_drive", 128'({a_oe0[0], b_oe0[0], dir_ack0[0]}), 128'(3'b101));

    // back to A->B, then reverse a request during TURN
    dir0[0] = 1'b0;
    repeat (3) step();
    cmp("back_ab", 128'(b_oe0[0]), 128'(1));
    dir0[0] = 1'b1;
    step();
    cmp("rev_dead1", 128'({a_oe0[0], b_oe0[0]}), 128'(0));
    dir0[0] = 1'b0;
    step();
    cmp("rev_dead2", 128'({a_oe0[0], b_oe0[0]}), 128'(0));
    step();
    cmp("rev_drive", 128'({b_oe0[0], dir_ack0[0], act0[0]}), 128'(3'b101));

    // disable wins over a simultaneous direction change
    dir0[0] = 1'b1; en0[0] = 1'b0;
    step();
    cmp("dis_prio", 128'({busy0[0], act0[0], a_oe0[0], b_oe0[0]}), 128'(0));

    // channel independence: flip ch2 repeatedly
    en0 = '1; dir0 = '0;
    repeat (3) step();
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) dir0[2] = ~dir0[2];
      aIn0 = {$urandom, $urandom, $urandom, $urandom};
      bIn0 = {$urandom, $urandom, $urandom, $urandom};
      step();
      cmp("indep_oe", 128'({b_oe0[3], b_oe0[1:0], a_oe0[3], a_oe0[1:0]}), 128'(6'b111000));
    end

    // single dead cycle on the narrow instance
    en1 = 2'b01; dir1 = '0;
    step();
    cmp("t1_busy", 128'({busy1[0], b_oe1[0]}), 128'(2'b10));
    step();
    cmp("t1_drive", 128'({b_oe1[0], act1[0]}), 128'(2'b11));
    dir1[0] = 1'b1;
    step();
    cmp("t1_dead", 128'({a_oe1[0], b_oe1[0], busy1[0]}), 128'(3'b001));
    step();
    cmp("t1_flip", 128'({a_oe1[0], dir_ack1[0]}), 128'(2'b11));

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      rstN = ($urandom_range(0, 80) != 0);
      for (int c = 0; c < C0; c++) begin
        en0[c] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 5) == 0) dir0[c] = ~dir0[c];
      end
      for (int c = 0; c < C1; c++) begin
        en1[c] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 4) == 0) dir1[c] = ~dir1[c];
      end
      aIn0 = {$urandom, $urandom, $urandom, $urandom};
      bIn0 = {$urandom, $urandom, $urandom, $urandom};
      aIn1 = 16'($urandom);
      bIn1 = 16'($urandom);
      step();
    end

    @(posedge clk);
    #2;
    cmp("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
